// File: rtl/uart_pkg.sv
// Shared definitions for the UART host interface: register offsets, status
// layout, command byte format and the command sequencer state encoding.
package uart_pkg;

  localparam logic [2:0] UART_CR_OFFSET    = 3'd0;
  localparam logic [2:0] UART_SR_OFFSET    = 3'd1;
  localparam logic [2:0] UART_DIN0_OFFSET  = 3'd2;
  localparam logic [2:0] UART_DIN1_OFFSET  = 3'd3;
  localparam logic [2:0] UART_DOUT0_OFFSET = 3'd4;
  localparam logic [2:0] UART_DOUT1_OFFSET = 3'd5;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       busy;
    logic       done;
  } uart_sr_t;

  // Host command byte: upper nibble must be zero, rw=1 is a write.
  typedef struct packed {
    logic [3:0] rsvd;
    logic [2:0] addr;
    logic       rw;
  } uart_cmd_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    WRITE     = 3'd2,
    READ      = 3'd3,
    RDWAIT    = 3'd4,
    SEND      = 3'd5
  } uart_ctrl_state_t;

endpackage

// File: rtl/uart_cmd_timer.sv
// Saturating cycle counter used to bound the wait for a write-data byte.
// expired_o is high while the count sits at TIMEOUT_CYCLES-1.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && cnt_q != TW'(TIMEOUT_CYCLES))
      cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_reg_ctrl.sv
// Host-command sequencer: decodes UART command bytes into single register
// writes or reads and returns read data as one byte to the UART transmitter.
module uart_reg_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  timeout_err
);

  uart_ctrl_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  we_q, we_d, re_q, re_d;
  logic                  cmd_err_q, cmd_err_d, to_err_q, to_err_d;
  logic                  tmr_clr, tmr_en, tmr_exp;
  uart_cmd_t             cmd;

  assign cmd = uart_cmd_t'(rx_data);

  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clr),
    .enable_i  (tmr_en),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    cmd_err_d  = 1'b0;
    to_err_d   = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (rx_valid) begin
          if (cmd.rsvd != 4'd0) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d  = cmd.addr;
            state_d = cmd.rw ? WAIT_DATA : READ;
          end
        end
      end
      WAIT_DATA: begin
        tmr_en = 1'b1;
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = WRITE;
        end else if (tmr_exp) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        we_d    = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        re_d    = 1'b1;
        state_d = RDWAIT;
      end
      RDWAIT: begin
        // First RDWAIT cycle carries the read strobe; data lands the cycle after.
        if (!re_q) begin
          tx_data_d  = reg_rdata;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rx_valid && (state_q == WRITE || state_q == READ ||
                     state_q == RDWAIT || state_q == SEND))
      cmd_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cmd_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cmd_err_q  <= cmd_err_d;
      to_err_q   <= to_err_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = (state_q != IDLE);
  assign cmd_err     = cmd_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl: a table of single transactions plus
// hand-written sequences for backpressure, timeout, expiry race and reset.
module tb_uart_reg_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data, reg_wdata, reg_rdata;
  logic [2:0] reg_addr;
  logic       tx_valid, reg_we, reg_re, busy, cmd_err, timeout_err;
  logic [7:0] rd_val = 8'h00;

  int n_tests = 0, n_fail = 0;

  uart_reg_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .cmd_err(cmd_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid only the cycle after reg_re.
  always @(posedge clk) reg_rdata <= reg_re ? rd_val : 8'hEE;

  typedef struct {
    logic [7:0] cmd;
    bit         has_data;
    logic [7:0] data;
    logic [7:0] rdval;
    int         exp_we;
    int         exp_re;
    int         exp_err;
    bit         exp_busy;
    logic [2:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_tx;
  } vec_t;

  int         n_we, n_re, n_err, n_to, we_at, re_at, tx_at;
  bit         busy_seen;
  logic [2:0] we_addr, re_addr;
  logic [7:0] we_wdata, tx_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_we = 0; n_re = 0; n_err = 0; n_to = 0; we_at = 0; re_at = 0; tx_at = 0;
    busy_seen = 1'b0; we_addr = 0; re_addr = 0; we_wdata = 0; tx_d = 0;
  endtask

  // Sample outputs of the current cycle; i is the cycle index of the sequence.
  task automatic sample(input int i);
    if (reg_we) begin n_we++; we_at = i; we_addr = reg_addr; we_wdata = reg_wdata; end
    if (reg_re) begin n_re++; re_at = i; re_addr = reg_addr; end
    if (tx_valid && tx_at == 0) begin tx_at = i; tx_d = tx_data; end
    if (cmd_err) n_err++;
    if (timeout_err) n_to++;
    if (busy) busy_seen = 1'b1;
  endtask

  // Command in cycle 0, optional data byte in cycle 1, then 8 observed cycles.
  task automatic run_txn(input logic [7:0] cmd, input bit has_data, input logic [7:0] data);
    clr_mon();
    @(negedge clk); rx_data = cmd; rx_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 1 && has_data) rx_data = data;
      else rx_valid = 1'b0;
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h05, 1, 8'hA5, 8'h00, 1, 0, 0, 1, 3'd2, 8'hA5, 8'h00};
    vecs[1] = '{8'h0F, 1, 8'h7E, 8'h00, 1, 0, 0, 1, 3'd7, 8'h7E, 8'h00};
    vecs[2] = '{8'h02, 0, 8'h00, 8'h3C, 0, 1, 0, 1, 3'd1, 8'h00, 8'h3C};
    vecs[3] = '{8'h0E, 0, 8'h00, 8'hC3, 0, 1, 0, 1, 3'd7, 8'h00, 8'hC3};
    vecs[4] = '{8'h85, 0, 8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 8'h00, 8'h00};
    vecs[5] = '{8'hF0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 3'd0, 8'h00, 8'h00};
    vecs[6] = '{8'h00, 0, 8'h00, 8'h5A, 0, 1, 0, 1, 3'd0, 8'h00, 8'h5A};

    // Reset state
    @(negedge clk);
    check("rst_outputs", {tx_valid, reg_we, reg_re, busy, cmd_err, timeout_err}, 6'b0);
    check("rst_regs", {tx_data, reg_addr, reg_wdata}, 19'h0);
    rst_n = 1'b1;

    // Table-driven single transactions with tx_ready held high
    foreach (vecs[k]) begin
      rd_val = vecs[k].rdval;
      run_txn(vecs[k].cmd, vecs[k].has_data, vecs[k].data);
      check($sformatf("v%0d_n_we", k), n_we, vecs[k].exp_we);
      check($sformatf("v%0d_n_re", k), n_re, vecs[k].exp_re);
      check($sformatf("v%0d_n_err", k), n_err, vecs[k].exp_err);
      check($sformatf("v%0d_n_to", k), n_to, 0);
      check($sformatf("v%0d_busy", k), busy_seen, vecs[k].exp_busy);
      if (vecs[k].exp_we != 0) begin
        check($sformatf("v%0d_we_lat", k), we_at, 3);
        check($sformatf("v%0d_we_addr", k), we_addr, vecs[k].exp_addr);
        check($sformatf("v%0d_wdata", k), we_wdata, vecs[k].exp_wdata);
      end
      if (vecs[k].exp_re != 0) begin
        check($sformatf("v%0d_re_lat", k), re_at, 2);
        check($sformatf("v%0d_re_addr", k), re_addr, vecs[k].exp_addr);
        check($sformatf("v%0d_tx_lat", k), tx_at, 4);
        check($sformatf("v%0d_tx_data", k), tx_d, vecs[k].exp_tx);
      end
    end

    // Read with backpressure; extra byte during SEND is dropped
    tx_ready = 1'b0; rd_val = 8'h3C; clr_mon();
    begin
      int held;
      held = 0;
      @(negedge clk); rx_data = 8'h02; rx_valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
        @(negedge clk);
        sample(i);
        if (i >= 4 && i <= 8 && tx_valid && tx_data == 8'h3C) held++;
        if (i == 6) begin
          check("send_drop_err", cmd_err, 1'b1);
          check("send_drop_txd", tx_data, 8'h3C);
        end
        if (i == 9) check("bp_release", {tx_valid, busy}, 2'b00);
        rx_valid = (i == 5);
        rx_data  = (i == 5) ? 8'h07 : 8'h00;
        if (i == 8) tx_ready = 1'b1;
      end
      check("bp_held", held, 5);
      check("bp_n_re", n_re, 1);
      check("bp_re_addr", re_addr, 3'd1);
      check("bp_n_err", n_err, 1);
    end

    // Write command then silence: timeout
    clr_mon();
    @(negedge clk); rx_data = 8'h0B; rx_valid = 1'b1;
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      sample(i);
      if (i == TO)     check("to_before", {timeout_err, busy}, 2'b01);
      if (i == TO + 1) check("to_fire", {timeout_err, busy}, 2'b10);
      rx_valid = 1'b0;
    end
    check("to_pulses", n_to, 1);
    check("to_no_we", n_we, 0);
    rd_val = 8'h99;
    run_txn(8'h02, 0, 8'h00);
    check("after_to_n_re", n_re, 1);
    check("after_to_addr", re_addr, 3'd1);
    check("after_to_tx", tx_d, 8'h99);
    check("after_to_n_we", n_we, 0);

    // Data byte exactly on the expiry cycle wins
    clr_mon();
    @(negedge clk); rx_data = 8'h0B; rx_valid = 1'b1;
    for (int i = 1; i <= TO + 4; i++) begin
      @(negedge clk);
      sample(i);
      rx_valid = (i == TO);
      rx_data  = (i == TO) ? 8'h11 : 8'h00;
    end
    check("race_n_we", n_we, 1);
    check("race_we_lat", we_at, TO + 2);
    check("race_addr", we_addr, 3'd5);
    check("race_wdata", we_wdata, 8'h11);
    check("race_no_to", n_to, 0);

    // Back-to-back: read command the cycle the write returns to IDLE
    rd_val = 8'h6B; clr_mon();
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) sample(i);
      rx_valid = (i == 0 || i == 1 || i == 3);
      rx_data  = (i == 0) ? 8'h05 : (i == 1) ? 8'h5A : (i == 3) ? 8'h0C : 8'h00;
    end
    check("b2b_we_lat", we_at, 3);
    check("b2b_wdata", we_wdata, 8'h5A);
    check("b2b_re_lat", re_at, 5);
    check("b2b_re_addr", re_addr, 3'd6);
    check("b2b_tx", tx_d, 8'h6B);
    check("b2b_err", n_err, 0);

    // Asynchronous reset while tx_valid is high
    tx_ready = 1'b0; rd_val = 8'h42;
    @(negedge clk); rx_data = 8'h02; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_txv", tx_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {tx_valid, busy, reg_we, reg_re, cmd_err, timeout_err}, 6'b0);
    @(negedge clk); rst_n = 1'b1; tx_ready = 1'b1;
    run_txn(8'h05, 1, 8'h01);
    check("post_rst_n_we", n_we, 1);
    check("post_rst_addr", we_addr, 3'd2);
    check("post_rst_wdata", we_wdata, 8'h01);
    check("post_rst_err", n_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
